// File: rtl/axis_uart_tx.sv
// axis_uart_tx: accepts one AXI4-Stream word per handshake and serialises it as a UART frame on txd.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module axis_uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [18:0]           timer_q, timer_d;
  logic [15:0]           reload_q, reload_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  tready_q, tready_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic        hs;
  logic        bit_done;
  logic        load_frame;
  logic [15:0] p_in;
  logic [18:0] bit_len_m1;
  logic [18:0] bit_len_in_m1;

  assign hs            = input_axis_tvalid && tready_q;
  assign bit_done      = (timer_q == '0);
  // A prescale of zero would give a zero-length bit; run it as prescale 1 instead.
  assign p_in          = (prescale == 16'd0) ? 16'd1 : prescale;
  assign bit_len_m1    = {reload_q, 3'b000} - 19'd1;
  assign bit_len_in_m1 = {p_in, 3'b000} - 19'd1;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    reload_d   = reload_q;
    bit_cnt_d  = bit_cnt_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    tready_d   = tready_q;
    timer_d    = bit_done ? timer_q : timer_q - 19'd1;
    load_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        txd_d    = 1'b1;
        busy_d   = 1'b0;
        tready_d = 1'b1;
        if (hs) load_frame = 1'b1;
      end

      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
          timer_d   = bit_len_m1;
        end
      end

      S_DATA: begin
        if (bit_done) begin
          timer_d = bit_len_m1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = parity_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            txd_d     = shift_d[0];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
          timer_d = bit_len_m1;
        end
      end
`endif

      S_STOP: begin
        // Open tready one cycle early so it is visible during the last stop cycle.
        if (timer_q == 19'd1) tready_d = 1'b1;
        if (bit_done) begin
          if (hs) begin
            load_frame = 1'b1;
          end else begin
            state_d  = S_IDLE;
            txd_d    = 1'b1;
            busy_d   = 1'b0;
            tready_d = 1'b1;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        txd_d    = 1'b1;
        busy_d   = 1'b0;
        tready_d = 1'b0;
      end
    endcase

    if (load_frame) begin
      state_d   = S_START;
      shift_d   = input_axis_tdata;
      reload_d  = p_in;
      timer_d   = bit_len_in_m1;
      bit_cnt_d = '0;
      txd_d     = 1'b0;
      busy_d    = 1'b1;
      tready_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^input_axis_tdata;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      reload_q  <= '0;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      tready_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      reload_q  <= reload_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      tready_q  <= tready_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign input_axis_tready = tready_q;
  assign txd               = txd_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: a scoreboard of sent words, checked cycle by cycle against the serial line.
module tb_axis_uart_tx;
  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB = W + 2 + (PAR_EN ? 1 : 0);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] tdata = '0;
  logic         tvalid = 1'b0;
  logic         tready;
  logic         txd;
  logic         busy;
  logic [15:0]  prescale = 16'd1;

  always #5 clk = ~clk;

  axis_uart_tx #(.DATA_WIDTH(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .input_axis_tdata  (tdata),
    .input_axis_tvalid (tvalid),
    .input_axis_tready (tready),
    .txd               (txd),
    .busy              (busy),
    .prescale          (prescale)
  );

  typedef struct {
    logic [W-1:0] data;
    int           p;
    int           t0;
  } frame_t;

  frame_t sb[$];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_bit(input logic [W-1:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= W) return d[b-1];
    if (PAR_EN && b == W + 1) return ^d;
    return 1'b1;
  endfunction

  // Line monitor
  bit     in_frame = 1'b0;
  int     post_rst = 0;
  int     k = 0;
  int     p8 = 8;
  int     len = 80;
  int     last_end = 0;
  frame_t cur;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      post_rst = 0;
    end else begin
      post_rst++;
      if (!in_frame && txd === 1'b0) begin
        if (sb.size() == 0) begin
          check_val("unexpected_start", txd, 1'b1);
        end else begin
          cur = sb.pop_front();
          check_val("start_cycle", cyc, cur.t0);
          in_frame = 1'b1;
          k   = 0;
          p8  = 8 * cur.p;
          len = NB * p8;
        end
      end
      if (in_frame) begin
        check_val("txd_bit", txd, exp_bit(cur.data, k / p8));
        check_val("busy_frame", busy, 1'b1);
        check_val("tready_frame", tready, (k == len - 1) ? 1'b1 : 1'b0);
        k++;
        if (k == len) begin
          in_frame = 1'b0;
          last_end = cyc;
        end
      end else if (txd !== 1'b0) begin
        check_val("idle_txd", txd, 1'b1);
        check_val("idle_busy", busy, 1'b0);
        if (post_rst >= 2) check_val("idle_tready", tready, 1'b1);
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, input logic [15:0] ps, input bit hold,
                           output int t0);
    int     budget;
    frame_t f;
    budget = 0;
    tdata  = d;
    prescale = ps;
    tvalid = 1'b1;
    do begin
      @(negedge clk);
      budget++;
    end while (tready !== 1'b1 && budget < 5000);
    if (tready !== 1'b1) begin
      check_val("handshake_timeout", tready, 1'b1);
      tvalid = 1'b0;
      t0 = -1;
      return;
    end
    @(posedge clk);
    #1;
    t0     = cyc;
    f.data = d;
    f.p    = (ps == 16'd0) ? 1 : int'(ps);
    f.t0   = cyc;
    sb.push_back(f);
    if (!hold) begin
      tvalid   = 1'b0;
      tdata    = ~d;
      prescale = ps + 16'd3;
    end
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((sb.size() != 0 || in_frame) && b < 5000) begin
      @(negedge clk);
      b++;
    end
    check_val("drain_timeout", (sb.size() == 0 && !in_frame) ? 1 : 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int t1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_txd", txd, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_tready", tready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("tready_after_rst", tready, 1'b1);
    repeat (100) @(posedge clk);
    #1;

    send_word(8'h55, 16'd1, 1'b0, t0);
    wait_idle();
    check_val("frame_len_p1", last_end - t0, NB * 8 - 1);

    send_word(8'hA3, 16'd0, 1'b0, t0);
    wait_idle();
    check_val("frame_len_p0", last_end - t0, NB * 8 - 1);

    send_word(8'h01, 16'd2, 1'b1, t0);
    send_word(8'hFF, 16'd2, 1'b0, t1);
    wait_idle();
    check_val("b2b_gap", t1 - t0, NB * 16);

    send_word(8'h00, 16'd1, 1'b0, t0);
    while (cyc < t0 + 29) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_txd", txd, 1'b1);
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_tready", tready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_word(8'h7E, 16'd1, 1'b0, t0);
    wait_idle();

    send_word(8'h07, 16'd1, 1'b0, t0);
    wait_idle();
    check_val("frame_len_07", last_end - t0, NB * 8 - 1);
    send_word(8'h03, 16'd1, 1'b0, t0);
    wait_idle();
    check_val("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_uart_tx.md
# axis_uart_tx

AXI4-Stream to UART serial transmitter: accepts one DATA_WIDTH-bit word per handshake and shifts it out on `txd` as an 8N1-style frame (start bit, data LSB first, optional parity, one stop bit). Mirrors the receive path: same `prescale` convention, same AXI-Stream flavour, and it sits beside the receiver inside the UART top.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9 supported)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- input_axis_tdata  input  DATA_WIDTH  word to transmit
- input_axis_tvalid  input  1  word valid
- input_axis_tready  output  1  block can accept a word this cycle
- txd  output  1  serial line, idle high
- busy  output  1  frame in progress
- prescale  input  16  bit period = 8*prescale clk cycles

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: `txd`=1, `busy`=0, `input_axis_tready`=1.
- Handshake = `tvalid && tready` at a rising edge. On handshake: latch `tdata` into shift register, latch `prescale` into bit timer reload (P; `prescale`=0 treated as 1), go to START.
- START: `txd`=0 for 8P cycles.
- DATA: DATA_WIDTH bits, LSB first, 8P cycles each; shift register shifts right at each bit boundary.
- STOP: `txd`=1 for 8P cycles. In the last STOP cycle `tready` is 1; a handshake there goes directly to START (no idle gap); otherwise return to IDLE.
- Bit timer: 19-bit down-counter loaded with 8P-1 at each bit start; bit ends when it reaches 0. Bit counter counts data bits 0..DATA_WIDTH-1.
- `tdata` and `prescale` changes outside the handshake cycle have no effect on the frame in flight.
- `tvalid` may drop without handshake; no state change.

## Timing
- Reset values: `txd`=1, `busy`=0, `input_axis_tready`=0; all counters 0, state IDLE. `tready` rises the first cycle after `rst` deasserts.
- All outputs registered.
- Handshake at edge T: from cycle T+1 `txd`=0, `busy`=1, `tready`=0.
- Start bit: cycles T+1..T+8P. Data bit i: T+1+(i+1)*8P .. T+(i+2)*8P.
- Stop bit ends at cycle T+(DATA_WIDTH+2)*8P (without parity); `tready`=1 in that cycle; `busy` stays 1 in that cycle and drops next cycle only if no handshake occurred.
- Frame length: (DATA_WIDTH+2)*8P cycles (+8P with parity); back-to-back throughput: one word per frame length, no gap.
- Reset mid-frame: next cycle `txd`=1, `busy`=0, `tready`=0; latched word discarded, no partial stop bit emitted.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted between DATA and STOP, 8P cycles, `txd` = even parity (XOR of the DATA_WIDTH latched bits); frame length (DATA_WIDTH+3)*8P; `tready` returns in last STOP cycle accordingly.
- Undefined: no PARITY state, no parity logic; frame as above.

## Test plan
- Reset then idle, `tvalid`=0 for 100 cycles -> `txd`=1, `busy`=0, `tready`=1 from first post-reset cycle.
- `prescale`=1, send 0x55 -> `txd` sequence 0,1,0,1,0,1,0,1,0,1 each held exactly 8 cycles; `tready` back high at cycle T+80.
- `prescale`=0, send 0xA3 -> identical timing to `prescale`=1; bits 0,1,1,0,0,0,1,0,1,1.
- `prescale`=2, `tvalid` held high with 0x01 then 0xFF -> second start bit begins the cycle after first stop bit ends (cycle T+161), no idle gap; second frame bits all 1.
- `prescale`=1, send 0x00, assert `rst` at cycle T+30 -> `txd`=1, `busy`=0 next cycle; after release, 0x7E sends cleanly.
- With `UART_TX_PARITY_EN`, `prescale`=1, send 0x07 -> parity bit 1 after bit 7, stop bit, frame 88 cycles; send 0x03 -> parity bit 0.
